// File: rtl/rd_ptr_empty_ctrl_if.sv
// Read-side user interface of the async FIFO read controller.
// master : the FIFO consumer. It drives read_enable and aempty_value.
// slave  : rd_ptr_empty_ctrl. It drives read_data, the flags, the count and the level.
interface rd_ptr_empty_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] aempty_value;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  rdempty;
  logic                  rd_almost_empty;
  logic                  underflow;
  logic [PTR_W-1:0]      fifo_read_count;
  logic [PTR_W-1:0]      rd_level;

  modport master (
    output read_enable, aempty_value,
    input  read_data, rdempty, rd_almost_empty, underflow, fifo_read_count, rd_level
  );

  modport slave (
    input  read_enable, aempty_value,
    output read_data, rdempty, rd_almost_empty, underflow, fifo_read_count, rd_level
  );
endinterface

// File: rtl/rd_ptr_empty_ctrl.sv
// Read-domain control stage of the async FIFO.
// The block synchronizes the Gray write pointer into rclk and keeps the read pointer.
// It addresses the dual-port memory and exports the Gray read pointer to the write domain.
// Ports:
//   rclk, hw_rst_n : read clock, asynchronous active-low reset
//   sw_rst         : synchronous active-high soft reset
//   rd             : read-side interface (read_enable, aempty_value in; data and status out)
//   wptr_gray      : Gray write pointer from the wclk domain
//   mem_rdata      : combinational memory read data at raddr
//   raddr          : memory read address
//   rptr_gray      : registered Gray read pointer, to the write domain
module rd_ptr_empty_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned SYNC_STAGES = 2   // legal range 2..3
) (
  input  logic                  rclk,
  input  logic                  hw_rst_n,
  input  logic                  sw_rst,
  rd_ptr_empty_ctrl_if.slave    rd,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b = g;
    for (int unsigned i = 1; i < PTR_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;
  logic [PTR_W-1:0]                  rbin_q;
  logic [PTR_W-1:0]                  rptr_gray_q;
  logic [DATA_WIDTH-1:0]             rdata_q;
  logic                              rdempty_q;
  logic                              raempty_q;
  logic                              underflow_q;
  logic [PTR_W-1:0]                  count_q;
  logic [PTR_W-1:0]                  level_q;

  logic [PTR_W-1:0] wq_gray_c;
  logic [PTR_W-1:0] wq_bin_c;
  logic             accept_c;
  logic [PTR_W-1:0] rbin_n_c;
  logic [PTR_W-1:0] rgray_n_c;
  logic [PTR_W-1:0] level_n_c;

  // Write-pointer synchronizer; soft reset flushes it so stale pointers never reach the flags.
  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      sync_q <= '0;
    end else if (sw_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray};
    end
  end

  // Next-pointer and flag arithmetic. The flags use the post-read pointer, so the last read sets empty on the same edge.
  always_comb begin
    wq_gray_c = sync_q[SYNC_STAGES-1];
    wq_bin_c  = gray2bin(wq_gray_c);
    accept_c  = rd.read_enable && !rdempty_q;
    rbin_n_c  = rbin_q + PTR_W'(accept_c);
    rgray_n_c = rbin_n_c ^ (rbin_n_c >> 1);
    level_n_c = wq_bin_c - rbin_n_c;
  end

  // Read pointer, data, count and status registers.
  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      rdata_q     <= '0;
      count_q     <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      rdempty_q   <= 1'b1;
      raempty_q   <= 1'b1;
    end else if (sw_rst) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      rdata_q     <= '0;
      count_q     <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      rdempty_q   <= 1'b1;
      raempty_q   <= 1'b1;
    end else begin
      if (accept_c) begin
        rdata_q <= mem_rdata;
        count_q <= count_q + PTR_W'(1);
      end
      rbin_q      <= rbin_n_c;
      rptr_gray_q <= rgray_n_c;
      underflow_q <= rd.read_enable && rdempty_q;
      level_q     <= level_n_c;
      // Gray equality detects empty; a lagging synchronized pointer can only delay deassertion.
      rdempty_q   <= (rgray_n_c == wq_gray_c);
      raempty_q   <= (level_n_c <= PTR_W'(rd.aempty_value));
    end
  end

  assign raddr              = rbin_q[ADDR_WIDTH-1:0];
  assign rptr_gray          = rptr_gray_q;
  assign rd.read_data       = rdata_q;
  assign rd.rdempty         = rdempty_q;
  assign rd.rd_almost_empty = raempty_q;
  assign rd.underflow       = underflow_q;
  assign rd.fifo_read_count = count_q;
  assign rd.rd_level        = level_q;

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// Bench for rd_ptr_empty_ctrl. A behavioural occupancy model is compared against the DUT on every cycle.
// Directed phases also check hand-computed literal values.
module tb_rd_ptr_empty_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned SYNC = 2;

  logic          rclk = 1'b0;
  logic          hw_rst_n;
  logic          sw_rst;
  logic [AW:0]   wptr_gray;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr_gray;

  int            wbin;           // write pointer as the writer sees it, 0..63
  logic [DW-1:0] mem [32];

  int n_checks = 0;
  int n_errors = 0;

  rd_ptr_empty_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rif ();

  rd_ptr_empty_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC)) dut (
    .rclk      (rclk),
    .hw_rst_n  (hw_rst_n),
    .sw_rst    (sw_rst),
    .rd        (rif.slave),
    .wptr_gray (wptr_gray),
    .mem_rdata (mem_rdata),
    .raddr     (raddr),
    .rptr_gray (rptr_gray)
  );

  always #5 rclk = ~rclk;

  assign wptr_gray = 6'(wbin ^ (wbin >> 1));
  assign mem_rdata = mem[raddr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the occupancy equals the write pointer delayed by SYNC edges minus the reads accepted so far.
  int            m_rd;           // reads accepted since reset, mod 64
  int            m_cnt;
  int            wq_hist[$];     // write pointer samples still in flight through the synchronizer
  logic [DW-1:0] exp_rdata;
  logic          exp_under, exp_empty, exp_ae;
  int            exp_level;

  task automatic model_clear();
    m_rd      = 0;
    m_cnt     = 0;
    exp_rdata = '0;
    exp_under = 1'b0;
    exp_empty = 1'b1;
    exp_ae    = 1'b1;
    exp_level = 0;
    wq_hist.delete();
    repeat (SYNC) wq_hist.push_back(0);
  endtask

  initial model_clear();

  always @(posedge rclk or negedge hw_rst_n) begin
    int vis;
    if (!hw_rst_n) begin
      model_clear();
    end else if (sw_rst) begin
      model_clear();
    end else begin
      vis = wq_hist.pop_front();
      wq_hist.push_back(wbin);
      exp_under = rif.read_enable && exp_empty;
      if (rif.read_enable && !exp_empty) begin
        exp_rdata = mem[m_rd % 32];
        m_rd  = (m_rd + 1) % 64;
        m_cnt = (m_cnt + 1) % 64;
      end
      exp_level = ((vis - m_rd) % 64 + 64) % 64;
      exp_empty = (exp_level == 0);
      exp_ae    = (exp_level <= int'(rif.aempty_value));
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge rclk) begin
    #1;
    check("read_data",       64'(rif.read_data),       64'(exp_rdata));
    check("rdempty",         64'(rif.rdempty),         64'(exp_empty));
    check("rd_almost_empty", 64'(rif.rd_almost_empty), 64'(exp_ae));
    check("underflow",       64'(rif.underflow),       64'(exp_under));
    check("fifo_read_count", 64'(rif.fifo_read_count), 64'(m_cnt));
    check("rd_level",        64'(rif.rd_level),        64'(exp_level));
    check("raddr",           64'(raddr),               64'(m_rd % 32));
    check("rptr_gray",       64'(rptr_gray),           64'(m_rd ^ (m_rd >> 1)));
  end

  task automatic step(input int n);
    repeat (n) @(negedge rclk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | 32'(i + 1);
    hw_rst_n = 1'b0;
    sw_rst   = 1'b0;
    wbin     = 0;
    rif.read_enable  = 1'b1;
    rif.aempty_value = 5'd0;
    step(3);
    check("lit_rst_rdempty", 64'(rif.rdempty), 64'd1);
    check("lit_rst_ae",      64'(rif.rd_almost_empty), 64'd1);
    check("lit_rst_under",   64'(rif.underflow), 64'd0);
    check("lit_rst_raddr",   64'(raddr), 64'd0);
    check("lit_rst_rptr",    64'(rptr_gray), 64'd0);
    check("lit_rst_count",   64'(rif.fifo_read_count), 64'd0);
    check("lit_rst_level",   64'(rif.rd_level), 64'd0);

    // Underflow: three reads while empty.
    hw_rst_n = 1'b1;
    step(1);
    check("lit_uf_pulse", 64'(rif.underflow), 64'd1);
    step(2);
    check("lit_uf_pulse3", 64'(rif.underflow), 64'd1);
    rif.read_enable = 1'b0;
    step(1);
    check("lit_uf_low",   64'(rif.underflow), 64'd0);
    check("lit_uf_raddr", 64'(raddr), 64'd0);
    check("lit_uf_data",  64'(rif.read_data), 64'd0);

    // Single entry: visible on the third edge, read once.
    wbin = 1;
    step(2);
    check("lit_se_not_yet", 64'(rif.rdempty), 64'd1);
    step(1);
    check("lit_se_visible", 64'(rif.rdempty), 64'd0);
    check("lit_se_level",   64'(rif.rd_level), 64'd1);
    rif.read_enable = 1'b1;
    step(1);
    rif.read_enable = 1'b0;
    check("lit_se_data",    64'(rif.read_data), 64'hA5A5_0001);
    check("lit_se_empty",   64'(rif.rdempty), 64'd1);
    check("lit_se_count",   64'(rif.fifo_read_count), 64'd1);
    check("lit_se_raddr",   64'(raddr), 64'd1);
    check("lit_se_rptr",    64'(rptr_gray), 64'b000001);
    check("lit_se_under",   64'(rif.underflow), 64'd0);

    // Almost-empty threshold at 4 with six entries.
    rif.aempty_value = 5'd4;
    wbin = 7;
    step(3);
    check("lit_ae_level6", 64'(rif.rd_level), 64'd6);
    check("lit_ae_off",    64'(rif.rd_almost_empty), 64'd0);
    rif.read_enable = 1'b1;
    step(2);
    check("lit_ae_level4", 64'(rif.rd_level), 64'd4);
    check("lit_ae_on",     64'(rif.rd_almost_empty), 64'd1);
    step(4);
    check("lit_ae_empty",  64'(rif.rdempty), 64'd1);
    check("lit_ae_level0", 64'(rif.rd_level), 64'd0);
    rif.read_enable = 1'b0;
    step(1);

    // Asynchronous hard reset in mid-cycle while the FIFO is not empty.
    wbin = 9;
    step(3);
    #3;
    hw_rst_n = 1'b0;
    wbin     = 0;
    #1;
    check("lit_async_empty", 64'(rif.rdempty), 64'd1);
    check("lit_async_raddr", 64'(raddr), 64'd0);
    check("lit_async_level", 64'(rif.rd_level), 64'd0);
    @(negedge rclk);
    hw_rst_n = 1'b1;

    // Wrap: 32 entries, read them all, then 32 more after the write pointer wraps back to 0.
    wbin = 32;
    step(3);
    rif.read_enable = 1'b1;
    step(32);
    check("lit_wrap_rptr",  64'(rptr_gray), 64'b110000);
    check("lit_wrap_raddr", 64'(raddr), 64'd0);
    check("lit_wrap_empty", 64'(rif.rdempty), 64'd1);
    check("lit_wrap_count", 64'(rif.fifo_read_count), 64'd32);
    step(1);
    check("lit_wrap_under", 64'(rif.underflow), 64'd1);
    wbin = 0;
    step(35);
    rif.read_enable = 1'b0;
    step(1);
    check("lit_wrap64_count", 64'(rif.fifo_read_count), 64'd0);
    check("lit_wrap64_rptr",  64'(rptr_gray), 64'd0);
    check("lit_wrap64_raddr", 64'(raddr), 64'd0);
    check("lit_wrap64_empty", 64'(rif.rdempty), 64'd1);

    // Soft reset mid-stream while reading.
    wbin = 5;
    step(3);
    check("lit_sw_level5", 64'(rif.rd_level), 64'd5);
    rif.read_enable = 1'b1;
    step(2);
    sw_rst = 1'b1;
    step(1);
    check("lit_sw_count", 64'(rif.fifo_read_count), 64'd0);
    check("lit_sw_raddr", 64'(raddr), 64'd0);
    check("lit_sw_empty", 64'(rif.rdempty), 64'd1);
    check("lit_sw_under", 64'(rif.underflow), 64'd0);
    check("lit_sw_level", 64'(rif.rd_level), 64'd0);
    check("lit_sw_data",  64'(rif.read_data), 64'd0);
    sw_rst = 1'b0;
    rif.read_enable = 1'b0;
    step(3);
    check("lit_sw_resync", 64'(rif.rd_level), 64'd5);
    check("lit_sw_nempty", 64'(rif.rdempty), 64'd0);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
